// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Holds the controller state encoding and divisor limits.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV     = 2;
    localparam int unsigned DEFAULT_DIV = 50000;

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter for the clock divider: counts 0..div-1 and flags the wrap.
// Also exposes the next count so the owner can register derived outputs.
module clk_div_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] cnt_nxt_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        wrap_o = en_i && !load_i && (cnt_q >= div_i - WIDTH'(1));
        cnt_d  = cnt_q;
        if (load_i || wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    assign cnt_nxt_o = cnt_d;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: run/idle FSM, divisor handshake and registered
// tick / square-wave outputs around the clk_div_cnt period counter.
module clk_div_ctrl #(
    parameter int          WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             busy,
    output logic [WIDTH-1:0] cur_div,
    output logic             clk_divider,
    output logic             tick
);

    import clk_div_pkg::*;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_d;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] pend_d;
    logic             err_q;
    logic             err_d;
    logic             tick_q;
    logic             tick_d;
    logic             clko_q;
    logic             clko_d;

    logic             accept;
    logic             legal;
    logic             take;
    logic             cnt_load;
    logic             wrap;
    logic [WIDTH-1:0] cnt_nxt;

    assign accept   = cfg_valid && cfg_ready;
    assign legal    = cfg_div >= WIDTH'(MIN_DIV);
    assign take     = accept && legal;
    assign cnt_load = (state_q == ST_IDLE) || !en;

    clk_div_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk       (clk),
        .rst_ni    (rst),
        .load_i    (cnt_load),
        .en_i      (en),
        .div_i     (div_q),
        .cnt_nxt_o (cnt_nxt),
        .wrap_o    (wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN:  if (take) state_d = ST_PEND;
                ST_PEND: if (wrap) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        unique case (1'b1)
            (state_q == ST_PEND): begin
                cfg_ready = 1'b0;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // A latched divisor is never dropped: it lands at the wrap or on idle entry.
    always_comb begin
        div_d  = div_q;
        pend_d = pend_q;
        if (state_q == ST_IDLE) begin
            if (take) div_d = cfg_div;
        end else if (!en) begin
            if (state_q == ST_PEND) begin
                div_d = pend_q;
            end else if (take) begin
                div_d = cfg_div;
            end
            pend_d = '0;
        end else if (state_q == ST_PEND) begin
            if (wrap) begin
                div_d  = pend_q;
                pend_d = '0;
            end
        end else if (take) begin
            pend_d = cfg_div;
        end
        err_d  = accept && !legal;
        tick_d = wrap;
        clko_d = (state_d != ST_IDLE) && (cnt_nxt < (div_d >> 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= WIDTH'(DEFAULT_DIV);
            pend_q <= '0;
            err_q  <= 1'b0;
            tick_q <= 1'b0;
            clko_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            pend_q <= pend_d;
            err_q  <= err_d;
            tick_q <= tick_d;
            clko_q <= clko_d;
        end
    end

    assign cur_div     = div_q;
    assign cfg_err     = err_q;
    assign tick        = tick_q;
    assign clk_divider = clko_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random
// traffic, compared against a period/queue level reference model.
module tb_clk_div_ctrl;

    localparam int W    = 16;
    localparam int DDIV = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         cfg_err;
    logic         busy;
    logic [W-1:0] cur_div;
    logic         clk_divider;
    logic         tick;

    int n_run;
    int n_fail;

    bit m_run;
    int m_pos;
    int m_div;
    int m_pq[$];
    bit m_tick;
    bit m_err;

    clk_div_ctrl #(
        .WIDTH       (W),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .busy        (busy),
        .cur_div     (cur_div),
        .clk_divider (clk_divider),
        .tick        (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_div  = DDIV;
        m_tick = 1'b0;
        m_err  = 1'b0;
        m_pq.delete();
    endtask

    // One clock of the divider seen as periods plus a one-deep request queue.
    task automatic model_step(input bit e, input bit v, input int d);
        bit acc;
        bit tk;
        acc    = v && (m_pq.size() == 0);
        tk     = acc && (d >= 2);
        m_err  = acc && (d < 2);
        m_tick = 1'b0;
        if (!e) begin
            if (m_pq.size() != 0) m_div = m_pq.pop_front();
            else if (tk) m_div = d;
            m_run = 1'b0;
            m_pos = 0;
        end else if (!m_run) begin
            if (tk) m_div = d;
            m_run = 1'b1;
            m_pos = 0;
        end else begin
            if (m_pos == m_div - 1) begin
                m_pos  = 0;
                m_tick = 1'b1;
                if (m_pq.size() != 0) m_div = m_pq.pop_front();
            end else begin
                m_pos++;
            end
            if (tk) m_pq.push_back(d);
        end
    endtask

    task automatic compare_all();
        chk("tick", 32'(tick), 32'(m_tick));
        chk("clk_divider", 32'(clk_divider),
            32'(m_run && (m_pos < m_div / 2)));
        chk("cur_div", 32'(cur_div), 32'(m_div));
        chk("busy", 32'(busy), 32'(m_pq.size() != 0));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_pq.size() == 0));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic cyc(input bit e, input bit v, input int d);
        en        = e;
        cfg_valid = v;
        cfg_div   = d[W-1:0];
        model_step(e, v, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_tick"}, 32'(tick), 32'd0);
        chk({tag, "_clkdiv"}, 32'(clk_divider), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        chk({tag, "_div"}, 32'(cur_div), 32'(DDIV));
    endtask

    // Asserted between edges so the asynchronous path is what gets tested.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        #1 reset_chk(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int first_tick;
        int ticks;
        n_run     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        model_reset();
        @(negedge clk);
        reset_chk("reset");
        rst = 1'b1;

        first_tick = -1;
        for (int i = 1; i <= 13; i++) begin
            cyc(1'b1, 1'b0, 0);
            if (tick && first_tick < 0) first_tick = i;
        end
        chk("first_tick_latency", 32'(first_tick - 1), 32'd4);

        cyc(1'b1, 1'b1, 5);
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 0);

        cyc(1'b0, 1'b1, 4);
        cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 6);
        chk("busy_after_req6", 32'(busy), 32'd1);
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 0);

        cyc(1'b1, 1'b1, 1);
        chk("err_pulse", 32'(cfg_err), 32'd1);
        cyc(1'b1, 1'b0, 0);
        chk("err_one_cycle", 32'(cfg_err), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 0);

        cyc(1'b1, 1'b1, 8);
        cyc(1'b1, 1'b0, 0);
        cyc(1'b0, 1'b0, 0);
        chk("idle_entry_div8", 32'(cur_div), 32'd8);
        ticks = 0;
        first_tick = -1;
        for (int i = 1; i <= 18; i++) begin
            cyc(1'b1, 1'b0, 0);
            if (tick && first_tick < 0) first_tick = i;
            if (tick) ticks++;
        end
        chk("reenable_tick_8", 32'(first_tick - 1), 32'd8);
        chk("ticks_in_18", 32'(ticks), 32'd2);

        cyc(1'b1, 1'b1, 3);
        cyc(1'b1, 1'b0, 0);
        mid_reset("pend_reset");
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                mid_reset("rand_reset");
            end else begin
                cyc($urandom_range(0, 15) != 0,
                    $urandom_range(0, 4) == 0,
                    int'($urandom_range(0, 12)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
